// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: state encoding and default
// EX/MEM bundle widths.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam int DATA_W_EXMEM = 48;
  localparam int CTRL_W_EXMEM = 4;

  // State is {main_valid, skid_valid}; 2'b01 cannot be reached in normal operation.
  typedef enum logic [1:0] {
    S_EMPTY   = ST_EMPTY,
    S_ILLEGAL = 2'b01,
    S_ONE     = ST_ONE,
    S_FULL    = ST_FULL
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Upstream and downstream handshake bundle of one elastic pipeline stage.
interface pipe_stage_elastic_if #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 4
);
  // A transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and data/ctrl stay stable while valid && !ready.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_elastic_entry.sv
// One pipeline entry: valid bit plus data/ctrl register with load enable and
// a ctrl-only clear used for bubble insertion.
module pipe_entry #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_d,
  input  logic              load,
  input  logic              clr_ctrl,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (load) begin
      data_d = data_in;
      ctrl_d = ctrl_in;
    end else if (clr_ctrl) begin
      ctrl_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = ctrl_q;
endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: main register plus skid entry, synchronous flush
// with bubble insertion, and a saturating stall-cycle counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_EXMEM,
  parameter int CTRL_W = CTRL_W_EXMEM,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_elastic_if.slave  bus,
  output logic [CNT_W-1:0]     stall_cnt,
  output pipe_state_e          dbg_state
);
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic              main_valid_d, main_load, main_clr, main_from_skid;
  logic              skid_valid_d, skid_load, skid_clr;
  logic              acc, emit;
  pipe_state_e       state;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign state = pipe_state_e'({main_valid, skid_valid});
  // in_ready comes straight from a flop, so out_ready never reaches in_ready.
  assign bus.in_ready = !skid_valid;
  assign acc  = bus.in_valid & bus.in_ready;
  assign emit = main_valid & bus.out_ready;

  always_comb begin
    main_valid_d   = main_valid;
    skid_valid_d   = skid_valid;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_clr     = 1'b1;
      skid_clr     = 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (acc) begin
            main_load    = 1'b1;
            main_valid_d = 1'b1;
          end
        end
        S_ONE: begin
          if (acc && emit) begin
            main_load = 1'b1;
          end else if (acc) begin
            skid_load    = 1'b1;
            skid_valid_d = 1'b1;
          end else if (emit) begin
            main_valid_d = 1'b0;
          end
        end
        S_FULL: begin
          if (emit) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_valid_d   = 1'b0;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
          main_clr     = 1'b1;
          skid_clr     = 1'b1;
        end
      endcase
    end
  end

  assign main_data_in = main_from_skid ? skid_data : bus.in_data;
  assign main_ctrl_in = main_from_skid ? skid_ctrl : bus.in_ctrl;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk      (clk),
    .rst      (rst),
    .valid_d  (main_valid_d),
    .load     (main_load),
    .clr_ctrl (main_clr),
    .data_in  (main_data_in),
    .ctrl_in  (main_ctrl_in),
    .valid    (main_valid),
    .data     (main_data),
    .ctrl     (main_ctrl)
  );

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .valid_d  (skid_valid_d),
    .load     (skid_load),
    .clr_ctrl (skid_clr),
    .data_in  (bus.in_data),
    .ctrl_in  (bus.in_ctrl),
    .valid    (skid_valid),
    .data     (skid_data),
    .ctrl     (skid_ctrl)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  // Control is gated by valid so a bubble can never fire halt/MemWrite/RegWrite.
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.out_ctrl  = main_valid ? main_ctrl : '0;
  assign stall_cnt     = stall_cnt_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed vector table, async reset and
// saturation sequences, then random traffic against a two-deep queue model.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int DW = 48;
  localparam int CW = 4;
  localparam int EW = DW + CW;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic sat_flush;
  logic [15:0] stall_cnt;
  logic [2:0]  sat_cnt;
  pipe_state_e dbg_state;
  pipe_state_e sat_state;

  always #5 clk = ~clk;

  pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();
  pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) sat_bus ();

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stall_cnt),
    .dbg_state (dbg_state)
  );

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(3)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .flush     (sat_flush),
    .bus       (sat_bus),
    .stall_cnt (sat_cnt),
    .dbg_state (sat_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  int unsigned exp_stall;

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic [CW-1:0] ic;
    logic          ordy;
    logic          fl;
    logic          ev;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    logic          er;
    int            es;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                         input logic ordy, input logic fl, input logic ev,
                         input logic [DW-1:0] ed, input logic [CW-1:0] ec,
                         input logic er, input int es);
    vec_t v;
    v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.ed = ed; v.ec = ec; v.er = er; v.es = es;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                       input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.in_ctrl   = ic;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  localparam logic [DW-1:0] DA = 48'hA000_0000_000A;
  localparam logic [DW-1:0] DB = 48'hB000_0000_000B;
  localparam logic [DW-1:0] DC = 48'hC000_0000_000C;
  localparam logic [DW-1:0] DD = 48'hD000_0000_000D;
  localparam logic [DW-1:0] DE = 48'hE000_0000_000E;

  initial begin
    logic          iv, ordy, fl, v, acc, em;
    logic [63:0]   r64;
    logic [DW-1:0] rd;
    logic [CW-1:0] rc;
    logic [EW-1:0] head;
    logic [1:0]    exp_st;

    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    sat_flush         = 1'b0;
    sat_bus.in_valid  = 1'b0;
    sat_bus.in_data   = '0;
    sat_bus.in_ctrl   = '0;
    sat_bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_ctrl", bus.out_ctrl, 0);
    chk("reset out_data", bus.out_data, 0);
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset stall_cnt", stall_cnt, 0);
    rst = 1'b0;

    // Saturating counter on the CNT_W=3 instance.
    sat_bus.in_valid = 1'b1;
    sat_bus.in_data  = 48'h5;
    sat_bus.in_ctrl  = 4'h3;
    @(posedge clk); #1;
    sat_bus.in_valid = 1'b0;
    chk("sat out_valid", sat_bus.out_valid, 1);
    chk("sat out_ctrl", sat_bus.out_ctrl, 4'h3);
    repeat (3) @(posedge clk); #1;
    chk("sat cnt after 3", sat_cnt, 3);
    repeat (7) @(posedge clk); #1;
    chk("sat cnt after 10", sat_cnt, 7);
    repeat (2) @(posedge clk); #1;
    chk("sat cnt held", sat_cnt, 7);

    // Directed table: post-edge expectations.
    for (int i = 0; i < 8; i++)
      add_vec(1'b1, DW'(i + 1), 4'h1, 1'b1, 1'b0, 1'b1, DW'(i + 1), 4'h1, 1'b1, 0);
    add_vec(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b0, DW'(8), 4'h0, 1'b1, 0);
    add_vec(1'b1, DA, 4'b1010, 1'b1, 1'b0, 1'b1, DA, 4'b1010, 1'b1, 0);
    add_vec(1'b1, DB, 4'b0101, 1'b0, 1'b0, 1'b1, DA, 4'b1010, 1'b0, 1);
    add_vec(1'b0, '0, 4'h0, 1'b0, 1'b0, 1'b1, DA, 4'b1010, 1'b0, 2);
    add_vec(1'b1, DC, 4'hF, 1'b0, 1'b1, 1'b0, DA, 4'h0, 1'b1, 3);
    add_vec(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b0, DA, 4'h0, 1'b1, 3);
    add_vec(1'b1, DA, 4'b1010, 1'b1, 1'b0, 1'b1, DA, 4'b1010, 1'b1, 3);
    add_vec(1'b1, DB, 4'b0101, 1'b0, 1'b0, 1'b1, DA, 4'b1010, 1'b0, 4);
    add_vec(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b1, DB, 4'b0101, 1'b1, 4);
    add_vec(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b0, DB, 4'h0, 1'b1, 4);
    add_vec(1'b1, DD, 4'h3, 1'b1, 1'b0, 1'b1, DD, 4'h3, 1'b1, 4);
    add_vec(1'b1, DE, 4'h6, 1'b1, 1'b1, 1'b0, DD, 4'h0, 1'b1, 4);
    add_vec(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b0, DD, 4'h0, 1'b1, 4);

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].id, vecs[i].ic, vecs[i].ordy, vecs[i].fl);
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), bus.out_valid, vecs[i].ev);
      chk($sformatf("vec%0d out_data", i), bus.out_data, vecs[i].ed);
      chk($sformatf("vec%0d out_ctrl", i), bus.out_ctrl, vecs[i].ec);
      chk($sformatf("vec%0d in_ready", i), bus.in_ready, vecs[i].er);
      chk($sformatf("vec%0d stall_cnt", i), stall_cnt, 64'(vecs[i].es));
    end

    // Reset asserted while FULL must clear outputs before the next edge.
    drive(1'b1, DA, 4'b1010, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, DB, 4'b0101, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("pre-reset state full", 64'(dbg_state), 64'(ST_FULL));
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", bus.out_valid, 0);
    chk("async rst out_ctrl", bus.out_ctrl, 0);
    chk("async rst in_ready", bus.in_ready, 1);
    chk("async rst stall_cnt", stall_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_stall = 0;

    // Random traffic against a two-deep FIFO model.
    for (int cyc = 0; cyc < 1000; cyc++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ((cyc % 97) == 96);
      r64  = {$urandom(), $urandom()};
      rd   = r64[DW-1:0];
      rc   = CW'($urandom_range(0, 15));
      drive(iv, rd, rc, ordy, fl);
      @(negedge clk);
      v    = (exp_q.size() != 0);
      acc  = iv && (exp_q.size() < 2);
      em   = v && ordy;
      head = v ? exp_q[0] : '0;
      exp_st = (exp_q.size() == 0) ? ST_EMPTY : (exp_q.size() == 1) ? ST_ONE : ST_FULL;
      chk("rand out_valid", bus.out_valid, v);
      chk("rand in_ready", bus.in_ready, exp_q.size() < 2);
      chk("rand out_ctrl", bus.out_ctrl, head[EW-1:DW]);
      if (v) chk("rand out_data", bus.out_data, head[DW-1:0]);
      chk("rand stall_cnt", stall_cnt, 64'(exp_stall));
      chk("rand state", 64'(dbg_state), 64'(exp_st));
      @(posedge clk);
      if (em) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({rc, rd});
      if (fl) exp_q.delete();
      if (v && !ordy && exp_stall < 65535) exp_stall++;
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
